// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
// Operands are latched when a request is accepted in IDLE; q/r update only on
// entry to DONE, and done is held until go is seen low (four-phase handshake).
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q_q, res_q_d;
    logic [WIDTH-1:0] res_r_q, res_r_d;
    logic             dz_q, dz_d;

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             fits;
    logic [CW-1:0]    cnt_inc;

    assign rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, div_q};
    // A set top bit would mean the shifted value overflowed, which always fits.
    assign fits     = rem_q[WIDTH] | (rem_sh >= {1'b0, div_q});
    assign rem_step = fits ? rem_diff : rem_sh;
    assign quo_step = {quo_q[WIDTH-2:0], fits};
    assign cnt_inc  = cnt_q + CW'(1);

    assign q           = res_q_q;
    assign r           = res_r_q;
    assign div_by_zero = dz_q;
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        res_q_d = res_q_q;
        res_r_d = res_r_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    if (y != '0) begin
                        div_d   = y;
                        rem_d   = '0;
                        quo_d   = x;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = StRun;
                    end else begin
                        // Zero divisor: report immediately, skip iteration.
                        res_q_d = '0;
                        res_r_d = '0;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(WIDTH)) begin
                    res_q_d = quo_step;
                    res_r_d = rem_step[WIDTH-1:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!go) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            res_q_q <= '0;
            res_r_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            res_q_q <= res_q_d;
            res_r_q <= res_r_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and exhaustive self-checking bench for seq_divider.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       go;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] q;
    logic [3:0] r;
    logic       done;
    logic       busy;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .x           (x),
        .y           (y),
        .q           (q),
        .r           (r),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Full handshake: raise go, wait for done, hold go one extra cycle, drop it.
    // With scramble set, x/y are changed to 1/1 right after acceptance.
    task automatic run_div(input logic [3:0] xa, input logic [3:0] ya, input bit scramble);
        logic [3:0] eq;
        logic [3:0] er;
        int         edges;
        int         bcnt;
        eq = (ya != 0) ? xa / ya : 4'd0;
        er = (ya != 0) ? xa % ya : 4'd0;
        x  = xa;
        y  = ya;
        go = 1'b1;
        @(posedge clk); #1;
        check("dz_at_accept", div_by_zero, (ya == 0));
        if (scramble) begin
            x = 4'd1;
            y = 4'd1;
        end
        edges = 0;
        bcnt  = busy;
        while (!done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            bcnt += busy;
        end
        check("latency", edges, (ya != 0) ? 4 : 0);
        check("busy_cycles", bcnt, (ya != 0) ? 4 : 0);
        check("q", q, eq);
        check("r", r, er);
        check("dz", div_by_zero, (ya == 0));
        @(posedge clk); #1;
        check("done_held", done, 1);
        go = 1'b0;
        @(posedge clk); #1;
        check("done_drop", done, 0);
        check("q_hold_idle", q, eq);
        check("r_hold_idle", r, er);
    endtask

    initial begin
        rst = 1'b0;
        go  = 1'b0;
        x   = 4'd0;
        y   = 4'd0;
        #3;
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dz", div_by_zero, 0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        // Basic, zero divisor, recovery from zero divisor.
        run_div(4'd13, 4'd4, 1'b0);
        run_div(4'd7, 4'd0, 1'b0);
        run_div(4'd9, 4'd3, 1'b0);

        // Boundaries.
        run_div(4'd15, 4'd1, 1'b0);
        run_div(4'd3, 4'd7, 1'b0);
        run_div(4'd15, 4'd15, 1'b0);
        run_div(4'd0, 4'd5, 1'b0);

        // Operands changed during RUN must be ignored.
        run_div(4'd14, 4'd3, 1'b1);

        // Asynchronous reset two cycles into 12/5.
        x  = 4'd12;
        y  = 4'd5;
        go = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_before_rst", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_q", q, 0);
        check("midrst_r", r, 0);
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dz", div_by_zero, 0);
        go = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_after_rst", busy | done, 0);
        run_div(4'd12, 4'd5, 1'b0);

        // Exhaustive sweep.
        for (int i = 0; i < 256; i++) begin
            run_div(4'(i >> 4), 4'(i & 15), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider for the calculator datapath, sitting directly downstream of the control unit. The control unit pulses nothing: it raises `go` (its `go_div`) and waits for `done` (its `done_div`) and `div_by_zero`. The divider latches the operands from the X/Y registers and computes one quotient bit per clock. It returns the quotient and remainder to the output-select muxes feeding the high and low output registers.

## Interface

- WIDTH, 4, operand, quotient and remainder width in bits (≥2)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- go  in  1  start request; level, sampled only in IDLE
- x  in  WIDTH  dividend (unsigned)
- y  in  WIDTH  divisor (unsigned)
- q  out  WIDTH  quotient, registered
- r  out  WIDTH  remainder, registered
- done  out  1  result valid; held high in DONE
- busy  out  1  high in RUN
- div_by_zero  out  1  error flag for the most recent accepted request

## Operation

- States: IDLE, RUN, DONE. Encoding is free. `busy`, `done` and `div_by_zero` are registered or decoded from state, not from inputs.
- Reset (rst=0, any state, asynchronous): state←IDLE. q, r, done, busy, div_by_zero ←0. Internal dividend/remainder/count ←0.
- IDLE, go=1 at edge:
  - y≠0: latch x and y. Working remainder (WIDTH+1 bits) ←0, working quotient ←x, count ←0, div_by_zero ←0. Go to RUN.
  - y=0: q←0, r←0, div_by_zero←1. Go directly to DONE without iterating.
- IDLE, go=0: hold. q, r and div_by_zero keep the last result.
- RUN, each edge (restoring step):
  - Shift {rem, quo} left by 1.
  - If the shifted rem ≥ latched y: rem ← rem−y and the quotient LSB ←1; else the LSB ←0.
  - count ← count+1.
  - x, y and go are ignored during RUN.
- RUN, edge where count reaches WIDTH: q ← final quotient, r ← final remainder[WIDTH-1:0]. Go to DONE.
- q and r change only on entry to DONE. During RUN they keep the previous result.
- DONE: done=1. Stay while go=1 (four-phase handshake). On an edge with go=0, go to IDLE; done falls.
- Arithmetic:
  - Unsigned only.
  - The invariant x = q·y + r with r < y holds for every y≠0.
  - The remainder register is WIDTH+1 bits so the compare never overflows.

## Timing

- go sampled at edge E0 with y≠0: RUN for edges E1…E_WIDTH. done, q and r are valid after E_WIDTH, i.e. WIDTH cycles of latency.
- y=0: done=1, div_by_zero=1 after E0, i.e. 1 cycle of latency.
- busy=1 exactly from after E0 to after E_WIDTH−1 (WIDTH cycles).
- done stays high until the first edge with go=0. Minimum DONE dwell is one cycle.
- Back-to-back requests: go must be seen low in DONE to return to IDLE. A new go is accepted at the following edge at the earliest.
- div_by_zero stays valid until the next accepted request. It clears at the E0 of a y≠0 request.
- Reset during RUN aborts at once. The previous q and r are lost (cleared to 0).

## Test plan

- WIDTH=4, x=13, y=4, go for one sampling edge then held → busy for 4 cycles, then done=1, q=3, r=1, div_by_zero=0. done is held while go=1 and drops one edge after go=0.
- x=7, y=0 → one edge after acceptance: done=1, div_by_zero=1, q=0, r=0, busy never high. Then x=9, y=3 → div_by_zero clears at acceptance; q=3, r=0.
- Boundaries: 15/1 → q=15, r=0. 3/7 → q=0, r=3. 15/15 → q=1, r=0. 0/5 → q=0, r=0. Each has latency exactly 4 cycles.
- Operand change mid-RUN: x=14, y=3 accepted, then x=1, y=1 driven during RUN → q=4, r=2.
- Reset mid-RUN: assert rst=0 two cycles into 12/5 → all outputs 0 and state IDLE immediately (no clock needed). After release, 12/5 → q=2, r=2.
- Exhaustive sweep, WIDTH=4: all 256 x/y pairs through the full handshake → q=x/y and r=x%y for y≠0, div_by_zero=1 for y=0. The previous result is held in IDLE between requests.
